// File: rtl/divider_arb_pkg.sv
// Shared constants for the divider arbiter: default operand width
// and the binary FSM state encoding.
package divider_arb_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DACK  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/divider_rr_pick.sv
// Combinational two-way round-robin pick.
// Ports: Req0/Req1 requests, Ptr priority pointer; Valid any request,
// Sel winning requester index.
module divider_rr_pick (
    input  logic Req0,
    input  logic Req1,
    input  logic Ptr,
    output logic Valid,
    output logic Sel
);

    assign Valid = Req0 | Req1;

    // Ptr only matters on a tie; a sole requester always wins.
    assign Sel = (Req0 && Req1) ? Ptr : Req1;

endmodule

// File: rtl/divider_arbiter.sv
// Two-requester front end sharing one iterative divider.
// Ports: Clk, Reset (sync, active-high); Req/X/Y/Ack per requester;
// Gnt/Done per requester; Quotient, Remainder, DivErr result;
// Div_* handshake and operands towards the divider.
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] X0,
    input  logic [WIDTH-1:0] Y0,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] Y1,
    input  logic             Ack0,
    input  logic             Ack1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivErr,
    output logic [WIDTH-1:0] Div_Xin,
    output logic [WIDTH-1:0] Div_Yin,
    output logic             Div_Start,
    output logic             Div_Ack,
    input  logic             Div_Done,
    input  logic [WIDTH-1:0] Div_Quotient,
    input  logic [WIDTH-1:0] Div_Remainder
);

    logic [2:0]       state;
    logic             ptr;
    logic             sel;
    logic             pick_valid;
    logic             pick_sel;
    logic             ack_sel;
    logic [WIDTH-1:0] win_x;
    logic [WIDTH-1:0] win_y;

    divider_rr_pick u_pick (
        .Req0  (Req0),
        .Req1  (Req1),
        .Ptr   (ptr),
        .Valid (pick_valid),
        .Sel   (pick_sel)
    );

    assign ack_sel = sel ? Ack1 : Ack0;
    assign win_x   = pick_sel ? X1 : X0;
    assign win_y   = pick_sel ? Y1 : Y0;

    // Div_Start and Div_Ack are registered from their states, so each
    // shows one cycle after START/DACK and is a single-cycle pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            sel       <= 1'b0;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Done0     <= 1'b0;
            Done1     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivErr    <= 1'b0;
            Div_Xin   <= '0;
            Div_Yin   <= '0;
            Div_Start <= 1'b0;
            Div_Ack   <= 1'b0;
        end else begin
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Div_Start <= 1'b0;
            Div_Ack   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        sel     <= pick_sel;
                        Gnt0    <= ~pick_sel;
                        Gnt1    <= pick_sel;
                        Div_Xin <= win_x;
                        Div_Yin <= win_y;
                        if (win_y == '0) begin
                            // Zero divisor: answer locally, bypass divider.
                            Quotient  <= '1;
                            Remainder <= win_x;
                            DivErr    <= 1'b1;
                            Done0     <= ~pick_sel;
                            Done1     <= pick_sel;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    Div_Start <= 1'b1;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Div_Done) begin
                        Quotient  <= Div_Quotient;
                        Remainder <= Div_Remainder;
                        DivErr    <= 1'b0;
                        state     <= ST_DACK;
                    end
                end
                ST_DACK: begin
                    Div_Ack <= 1'b1;
                    Done0   <= ~sel;
                    Done1   <= sel;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (ack_sel) begin
                        Done0 <= 1'b0;
                        Done1 <= 1'b0;
                        ptr   <= ~sel;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
